// File: rtl/way_mutex_mon_pkg.sv
// rtl/way_mutex_mon_pkg.sv - shared types and helpers for the way-hit mutex monitor
//
// Purpose: FSM state type, a population-count helper and a saturating
// increment used by way_mutex_mon and reusable by sibling monitors.
// Ports: none (package).

package way_mutex_mon_pkg;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_FAILED = 2'd2
  } state_t;

  // Vectors up to 16 bits; callers zero-extend narrower vectors.
  function automatic logic [4:0] popcnt16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  // Holds at max_v instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/way_mutex_mon_onehot_chk.sv
// rtl/way_mutex_mon_onehot_chk.sv - combinational zero/one-hot legality check
//
// Purpose: flags a vector with more than one bit set, or with no bit set
// when ALLOW_ZERO=0.
// Ports:
//   vec     in  WAYS  vector under test
//   illegal out 1     1 = vector violates the mutex rule

module onehot_chk #(
  parameter int WAYS       = 4,
  parameter int ALLOW_ZERO = 1
) (
  input  logic [WAYS-1:0] vec,
  output logic            illegal
);

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  logic [WAYS-1:0] low_cleared;

  assign low_cleared = vec & (vec - WAYS'(1));
  assign illegal     = (|low_cleared) | ((ALLOW_ZERO == 0) && (vec == '0));

endmodule

// File: rtl/way_mutex_mon.sv
// rtl/way_mutex_mon.sv - N-way hit-vector mutex monitor with latched fail
//
// Purpose: checks a qualified hit/way-select vector for zero-or-one-hot
// (or strict one-hot) each cycle after a post-reset arming window, counts
// violations with saturation, captures the first failing vector/id and
// drives a sticky fail into the chip monitor.
// Optional build macro: WAY_MUTEX_MON_POPCNT_EN adds max_pop.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   chk_en              0 = count/capture only, never raise fail
//   hit_vec, tag_err    hit vector and per-way tag errors (any error suppresses)
//   miss, cam_vld       lookup miss (suppresses) and lookup valid (required)
//   id                  instance id captured with the first violation
//   clr                 clears count, capture and fail (arming is kept)
//   viol                registered one-cycle violation pulse
//   viol_cnt            saturating violation count
//   first_vec/id/vld    first violation capture since reset/clr
//   fail                sticky fail
//   max_pop             (macro only) largest popcount seen on a violation

module way_mutex_mon #(
  parameter int WAYS        = 4,
  parameter int ALLOW_ZERO  = 1,
  parameter int ARM_DLY     = 8,
  parameter int CNT_W       = 8,
  parameter int FAIL_THRESH = 1,
  parameter int ID_W        = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chk_en,
  input  logic [WAYS-1:0]   hit_vec,
  input  logic [WAYS-1:0]   tag_err,
  input  logic              miss,
  input  logic              cam_vld,
  input  logic [ID_W-1:0]   id,
  input  logic              clr,
  output logic              viol,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic [WAYS-1:0]   first_vec,
  output logic [ID_W-1:0]   first_id,
  output logic              first_vld,
  output logic              fail
`ifdef WAY_MUTEX_MON_POPCNT_EN
  ,
  output logic [$clog2(WAYS):0] max_pop
`endif
);

  import way_mutex_mon_pkg::*;

  if (WAYS < 2 || WAYS > 16) begin : g_bad_ways
    $error("way_mutex_mon: WAYS must be in 2..16");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("way_mutex_mon: CNT_W must be in 1..32");
  end

  localparam int ARM_W = (ARM_DLY > 1) ? $clog2(ARM_DLY) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'((ARM_DLY > 0) ? ARM_DLY - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH = CNT_W'(FAIL_THRESH);
  // With no arming window the monitor comes out of reset already checking.
  localparam state_t RST_STATE = (ARM_DLY == 0) ? ST_ARMED : ST_WAIT;

  state_t           state;
  logic [ARM_W-1:0] arm_cnt;
  logic             illegal;
  logic             qual;
  logic             bad;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_next;
  logic             fail_set;

  onehot_chk #(
    .WAYS      (WAYS),
    .ALLOW_ZERO(ALLOW_ZERO)
  ) u_onehot_chk (
    .vec    (hit_vec),
    .illegal(illegal)
  );

  always_comb begin
    qual     = cam_vld & ~miss & ~(|tag_err) & (state != ST_WAIT);
    bad      = qual & illegal;
    cnt_inc  = CNT_W'(sat_inc(32'(viol_cnt), 32'(CNT_MAX)));
    cnt_next = bad ? cnt_inc : viol_cnt;
    // Level-sensitive on the count so a late chk_en still trips fail.
    fail_set = chk_en & (cnt_next >= THRESH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_STATE;
      arm_cnt   <= '0;
      viol      <= 1'b0;
      viol_cnt  <= '0;
      first_vec <= '0;
      first_id  <= '0;
      first_vld <= 1'b0;
      fail      <= 1'b0;
    end else begin
      viol <= bad;

      case (state)
        ST_WAIT: begin
          if (arm_cnt == ARM_LAST) begin
            state <= ST_ARMED;
          end else begin
            arm_cnt <= arm_cnt + ARM_W'(1);
          end
        end
        ST_ARMED: begin
          if (!clr && fail_set) begin
            state <= ST_FAILED;
          end
        end
        ST_FAILED: begin
          // clr drops fail but keeps checking; it never re-enters WAIT.
          if (clr) begin
            state <= ST_ARMED;
          end
        end
        default: state <= RST_STATE;
      endcase

      // clr beats a simultaneous violation; viol above still pulses.
      if (clr) begin
        viol_cnt  <= '0;
        first_vec <= '0;
        first_id  <= '0;
        first_vld <= 1'b0;
        fail      <= 1'b0;
      end else begin
        viol_cnt <= cnt_next;
        if (bad && !first_vld) begin
          first_vec <= hit_vec;
          first_id  <= id;
          first_vld <= 1'b1;
        end
        if (fail_set) begin
          fail <= 1'b1;
        end
      end
    end
  end

`ifdef WAY_MUTEX_MON_POPCNT_EN
  localparam int POP_W = $clog2(WAYS) + 1;

  logic [POP_W-1:0] pop;

  assign pop = POP_W'(popcnt16(16'(hit_vec)));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      max_pop <= '0;
    end else if (bad && (pop > max_pop)) begin
      max_pop <= pop;
    end
  end
`endif

endmodule

// File: tb/tb_way_mutex_mon.sv
// tb/tb_way_mutex_mon.sv - self-checking bench for way_mutex_mon
//
// Two instances share the stimulus: A (zero-hot legal, 8-cycle arming,
// 2-bit counter, threshold 3) and B (strict one-hot, no arming, 8-bit
// counter, threshold 1). A cycle-level reference model built from the
// behavioural rules predicts every output of both.

module tb_way_mutex_mon;

  logic       clk = 1'b0;
  logic       rst, chk_en, miss, cam_vld, clr;
  logic [3:0] hit_vec, tag_err;
  logic [2:0] id;

  logic       a_viol, a_first_vld, a_fail;
  logic [1:0] a_viol_cnt;
  logic [3:0] a_first_vec;
  logic [2:0] a_first_id;
  logic       b_viol, b_first_vld, b_fail;
  logic [7:0] b_viol_cnt;
  logic [3:0] b_first_vec;
  logic [2:0] b_first_id;
`ifdef WAY_MUTEX_MON_POPCNT_EN
  logic [2:0] a_max_pop, b_max_pop;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model parameters and state, index 0 = A, 1 = B.
  int m_az[2]  = '{1, 0};
  int m_arm[2] = '{8, 0};
  int m_max[2] = '{3, 255};
  int m_thr[2] = '{3, 1};
  int m_since[2], m_cnt[2], m_fvec[2], m_fid[2], m_fvld[2], m_fail[2], m_viol[2], m_pop[2];

  always #5 clk = ~clk;

  way_mutex_mon #(
    .WAYS(4), .ALLOW_ZERO(1), .ARM_DLY(8), .CNT_W(2), .FAIL_THRESH(3), .ID_W(3)
  ) dut_a (
    .clk(clk), .rst(rst), .chk_en(chk_en), .hit_vec(hit_vec), .tag_err(tag_err),
    .miss(miss), .cam_vld(cam_vld), .id(id), .clr(clr),
    .viol(a_viol), .viol_cnt(a_viol_cnt), .first_vec(a_first_vec),
    .first_id(a_first_id), .first_vld(a_first_vld), .fail(a_fail)
`ifdef WAY_MUTEX_MON_POPCNT_EN
    , .max_pop(a_max_pop)
`endif
  );

  way_mutex_mon #(
    .WAYS(4), .ALLOW_ZERO(0), .ARM_DLY(0), .CNT_W(8), .FAIL_THRESH(1), .ID_W(3)
  ) dut_b (
    .clk(clk), .rst(rst), .chk_en(chk_en), .hit_vec(hit_vec), .tag_err(tag_err),
    .miss(miss), .cam_vld(cam_vld), .id(id), .clr(clr),
    .viol(b_viol), .viol_cnt(b_viol_cnt), .first_vec(b_first_vec),
    .first_id(b_first_id), .first_vld(b_first_vld), .fail(b_fail)
`ifdef WAY_MUTEX_MON_POPCNT_EN
    , .max_pop(b_max_pop)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int  pc, nc;
    bit  q, bad;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_since[m] = 0; m_cnt[m] = 0; m_fvec[m] = 0; m_fid[m] = 0;
        m_fvld[m] = 0; m_fail[m] = 0; m_viol[m] = 0; m_pop[m] = 0;
      end else begin
        pc  = $countones(hit_vec);
        q   = cam_vld && !miss && (tag_err == 4'd0) && (m_since[m] >= m_arm[m]);
        bad = q && ((pc > 1) || (m_az[m] == 0 && pc == 0));
        m_viol[m] = bad;
        nc = bad ? ((m_cnt[m] + 1 > m_max[m]) ? m_max[m] : m_cnt[m] + 1) : m_cnt[m];
        if (clr) begin
          m_cnt[m] = 0; m_fvec[m] = 0; m_fid[m] = 0; m_fvld[m] = 0;
          m_fail[m] = 0; m_pop[m] = 0;
        end else begin
          if (bad && m_fvld[m] == 0) begin
            m_fvec[m] = int'(hit_vec); m_fid[m] = int'(id); m_fvld[m] = 1;
          end
          m_cnt[m] = nc;
          if (chk_en && nc >= m_thr[m]) m_fail[m] = 1;
          if (bad && pc > m_pop[m]) m_pop[m] = pc;
        end
        if (m_since[m] < 1000000) m_since[m]++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("a_viol", 32'(a_viol), m_viol[0]);
    chk("a_viol_cnt", 32'(a_viol_cnt), m_cnt[0]);
    chk("a_first_vec", 32'(a_first_vec), m_fvec[0]);
    chk("a_first_id", 32'(a_first_id), m_fid[0]);
    chk("a_first_vld", 32'(a_first_vld), m_fvld[0]);
    chk("a_fail", 32'(a_fail), m_fail[0]);
    chk("b_viol", 32'(b_viol), m_viol[1]);
    chk("b_viol_cnt", 32'(b_viol_cnt), m_cnt[1]);
    chk("b_first_vec", 32'(b_first_vec), m_fvec[1]);
    chk("b_first_id", 32'(b_first_id), m_fid[1]);
    chk("b_first_vld", 32'(b_first_vld), m_fvld[1]);
    chk("b_fail", 32'(b_fail), m_fail[1]);
`ifdef WAY_MUTEX_MON_POPCNT_EN
    chk("a_max_pop", 32'(a_max_pop), m_pop[0]);
    chk("b_max_pop", 32'(b_max_pop), m_pop[1]);
`endif
  endtask

  task automatic run(input logic [3:0] hv, input logic [2:0] idv, input int n);
    hit_vec = hv;
    id      = idv;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; chk_en = 1'b1; hit_vec = 4'd0; tag_err = 4'd0;
    miss = 1'b0; cam_vld = 1'b0; id = 3'd0; clr = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_a_cnt", 32'(a_viol_cnt), 0);
    chk("rst_a_fail", 32'(a_fail), 0);

    // Arming window: A ignores cycles 0-7, checks cycle 8
    rst = 1'b0; cam_vld = 1'b1;
    run(4'b0011, 3'd0, 8);
    chk("arm_a_cnt_early", 32'(a_viol_cnt), 0);
    run(4'b0011, 3'd0, 1);
    chk("arm_a_viol", 32'(a_viol), 1);
    chk("arm_a_cnt", 32'(a_viol_cnt), 1);

    clr = 1'b1; cam_vld = 1'b0;
    run(4'b0000, 3'd0, 1);
    clr = 1'b0; cam_vld = 1'b1;

    // Zero / one-hot legality
    run(4'b0000, 3'd0, 1);
    chk("zero_a_viol", 32'(a_viol), 0);
    chk("zero_b_viol", 32'(b_viol), 1);
    run(4'b0100, 3'd0, 1);
    run(4'b1000, 3'd0, 1);
    chk("onehot_a_cnt", 32'(a_viol_cnt), 0);

    // Suppression by tag error, miss, invalid lookup
    tag_err = 4'b0010; run(4'b1100, 3'd0, 1); tag_err = 4'd0;
    miss = 1'b1;       run(4'b1100, 3'd0, 1); miss = 1'b0;
    cam_vld = 1'b0;    run(4'b1100, 3'd0, 1); cam_vld = 1'b1;
    chk("supp_a_cnt", 32'(a_viol_cnt), 0);

    // Threshold and first-failure capture
    run(4'b1010, 3'd5, 1);
    run(4'b0110, 3'd2, 1);
    chk("thr_a_fail_early", 32'(a_fail), 0);
    run(4'b1111, 3'd1, 1);
    chk("thr_a_fail", 32'(a_fail), 1);
    chk("thr_a_first_vec", 32'(a_first_vec), 32'hA);
    chk("thr_a_first_id", 32'(a_first_id), 5);

    // chk_en low: count without fail, then late enable
    clr = 1'b1; cam_vld = 1'b0; run(4'b0000, 3'd0, 1); clr = 1'b0;
    chk_en = 1'b0; cam_vld = 1'b1;
    run(4'b0011, 3'd3, 3);
    chk("en0_a_fail", 32'(a_fail), 0);
    chk("en0_a_cnt", 32'(a_viol_cnt), 3);
    cam_vld = 1'b0; chk_en = 1'b1;
    run(4'b0000, 3'd0, 1);
    chk("late_en_a_fail", 32'(a_fail), 1);

    // Saturation, then clr against a simultaneous violation
    clr = 1'b1; run(4'b0000, 3'd0, 1); clr = 1'b0;
    cam_vld = 1'b1;
    run(4'b0011, 3'd4, 5);
    chk("sat_a_cnt", 32'(a_viol_cnt), 3);
    clr = 1'b1; run(4'b0101, 3'd6, 1); clr = 1'b0;
    chk("clrv_a_cnt", 32'(a_viol_cnt), 0);
    chk("clrv_a_first_vld", 32'(a_first_vld), 0);
    chk("clrv_a_viol", 32'(a_viol), 1);

    // Reset out of FAILED restarts the arming window
    run(4'b1111, 3'd7, 3);
    rst = 1'b1; run(4'b1111, 3'd0, 1); rst = 1'b0;
    chk("rstf_a_fail", 32'(a_fail), 0);
    chk("rstf_a_cnt", 32'(a_viol_cnt), 0);
    run(4'b1111, 3'd0, 8);
    chk("rearm_a_cnt", 32'(a_viol_cnt), 0);
    run(4'b1111, 3'd0, 1);
    chk("rearm_a_cnt1", 32'(a_viol_cnt), 1);
`ifdef WAY_MUTEX_MON_POPCNT_EN
    chk("pop_a_max", 32'(a_max_pop), 4);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(63) == 0);
      clr     = ($urandom_range(15) == 0);
      chk_en  = ($urandom_range(3) != 0);
      cam_vld = ($urandom_range(7) != 0);
      miss    = ($urandom_range(7) == 0);
      tag_err = ($urandom_range(7) == 0) ? 4'($urandom) : 4'd0;
      id      = 3'($urandom);
      case ($urandom_range(3))
        0:       hit_vec = 4'($urandom);
        1:       hit_vec = 4'd0;
        default: hit_vec = 4'd1 << $urandom_range(3);
      endcase
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
